// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with majority-vote sampling,
// per-word error flags and a one-word holding register (valid/ready).
//
// Optional feature macro: UART_RX_BREAK_EN
//   When defined, a break frame pulses break_det instead of being delivered,
//   and the receiver waits for the line to return high before re-arming.
//
// Ports:
//   clk        system clock
//   rst_n      async active-low reset
//   rx_p       serial line, asynchronous, idle high
//   rx_data    received word, valid while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer accepts word when rx_valid & rx_ready
//   frame_err  word qualifier: any stop bit sampled 0
//   parity_err word qualifier: parity mismatch (0 if PARITY=0)
//   overrun    1-cycle pulse: completed word dropped
//   break_det  1-cycle pulse on break frame (0 unless UART_RX_BREAK_EN)
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_p,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID   = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_ferr;
  logic                   r_perr;
`ifdef UART_RX_BREAK_EN
  logic                   r_zero;
`endif
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;
  logic                   r_break_det;

  logic w_s;
  logic w_vote;
  logic w_tick;
  logic w_mid;
  logic w_par_x;
  logic w_perr;
  logic w_ferr_fin;
  logic w_last_stop;
`ifdef UART_RX_BREAK_EN
  logic w_brk_fin;
`endif

  // Synchronised line and 3-sample majority vote
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_vote  = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

  // Bit timing: mid-start check, then one evaluation per bit period at wrap
  assign w_tick  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_mid   = (r_cnt == CNT_W'(MID + 1));

  // Parity check: XOR over data plus parity vote is 1 for odd, 0 for even
  assign w_par_x = ^{r_shift, w_vote};
  assign w_perr  = (PARITY == 1) ? ~w_par_x : w_par_x;

  assign w_ferr_fin  = r_ferr | ~w_vote;
  assign w_last_stop = (r_idx == IDX_W'(STOP_BITS - 1));

`ifdef UART_RX_BREAK_EN
  // Break qualifies on the first stop vote; later stop votes do not matter
  assign w_brk_fin = (r_idx == '0) ? (r_zero & ~w_vote) : r_zero;
`endif

  // Receiver FSM, synchroniser and holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sync       <= '1;
      r_hist       <= '1;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_ferr       <= 1'b0;
      r_perr       <= 1'b0;
`ifdef UART_RX_BREAK_EN
      r_zero       <= 1'b0;
`endif
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], rx_p};
      r_hist      <= {r_hist[1:0], w_s};
      r_overrun   <= 1'b0;
      r_break_det <= 1'b0;

      // Consumer accept; a same-cycle completion below re-sets valid
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_hist[0] && !w_s) r_state <= S_START;
        end

        S_START: begin
          if (w_mid) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_zero <= 1'b1;
`endif
            r_state <= w_vote ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
            r_zero  <= r_zero & ~w_vote;
`endif
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        S_PARITY: begin
          r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            r_perr  <= w_perr;
`ifdef UART_RX_BREAK_EN
            r_zero  <= r_zero & ~w_vote;
`endif
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            r_ferr <= w_ferr_fin;
`ifdef UART_RX_BREAK_EN
            if (r_idx == '0) r_zero <= r_zero & ~w_vote;
`endif
            if (w_last_stop) begin
              // Completion: return to IDLE at once so back-to-back frames work
              r_idx   <= '0;
              r_state <= S_IDLE;
`ifdef UART_RX_BREAK_EN
              if (w_brk_fin) begin
                r_break_det <= 1'b1;
                r_state     <= S_BRK_WAIT;
              end else
`endif
              if (!r_rx_valid || rx_ready) begin
                r_rx_data    <= r_shift;
                r_frame_err  <= w_ferr_fin;
                r_parity_err <= r_perr;
                r_rx_valid   <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

`ifdef UART_RX_BREAK_EN
        S_BRK_WAIT: begin
          r_cnt <= '0;
          if (w_s) r_state <= S_IDLE;
        end
`endif

        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign break_det  = r_break_det;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg.
// Instance A: 8N1, instance B: 8E1 (even parity). CLKS_PER_BIT = 16.
// Stimulus pushes expected words into per-instance queues; monitors pop and
// compare whenever a new word is loaded into the holding register.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;
  logic rdy_a = 1'b1;
  logic rdy_b = 1'b1;

  logic [7:0] data_a, data_b;
  logic val_a, val_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, bk_a, bk_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovr_a  = 0;
  int n_ovr_b  = 0;
  int n_brk_a  = 0;
  int n_brk_b  = 0;
  int exp_brk  = 0;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] exp_a, exp_b;
  logic       vprev_a = 1'b0;
  logic       vprev_b = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_p(rx_a), .rx_data(data_a), .rx_valid(val_a),
    .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
    .break_det(bk_a)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_p(rx_b), .rx_data(data_b), .rx_valid(val_b),
    .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b),
    .break_det(bk_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] pack(input logic [7:0] d, input logic fe, input logic pe);
    return {pe, fe, d};
  endfunction

  task automatic drive_a(input logic v, input int cycles);
    rx_a = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drive_b(input logic v, input int cycles);
    rx_b = v;
    repeat (cycles) @(negedge clk);
  endtask

  // 8N1 frame on line A; glitch_bit >= 0 inverts that data bit for 1 clk mid-bit
  task automatic frame_a(input logic [7:0] d, input logic stop, input int glitch_bit);
    drive_a(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_a(d[i], 8);
        drive_a(~d[i], 1);
        drive_a(d[i], 7);
      end else begin
        drive_a(d[i], CPB);
      end
    end
    drive_a(stop, CPB);
  endtask

  // 8-data-bit frame with explicit parity bit on line B
  task automatic frame_b(input logic [7:0] d, input logic par);
    drive_b(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_b(d[i], CPB);
    drive_b(par, CPB);
    drive_b(1'b1, CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_valid"},  32'(val_a),  32'h0);
    chk({tag, "_a_data"},   32'(data_a), 32'h0);
    chk({tag, "_a_ferr"},   32'(fe_a),   32'h0);
    chk({tag, "_a_perr"},   32'(pe_a),   32'h0);
    chk({tag, "_a_ovr"},    32'(ov_a),   32'h0);
    chk({tag, "_a_brk"},    32'(bk_a),   32'h0);
    chk({tag, "_b_valid"},  32'(val_b),  32'h0);
    chk({tag, "_b_data"},   32'(data_b), 32'h0);
  endtask

  // Monitor A: a word is presented when valid rises or reloads after accept
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ov_a) n_ovr_a++;
      if (bk_a) n_brk_a++;
      if (val_a && (!vprev_a || rdy_a)) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_word: got data 0x%0h, expected no word", data_a);
        end else begin
          exp_a = q_a.pop_front();
          chk("a_data",       32'(data_a), 32'(exp_a[7:0]));
          chk("a_frame_err",  32'(fe_a),   32'(exp_a[8]));
          chk("a_parity_err", 32'(pe_a),   32'(exp_a[9]));
        end
      end
      vprev_a = val_a;
    end
  end

  // Monitor B
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ov_b) n_ovr_b++;
      if (bk_b) n_brk_b++;
      if (val_b && (!vprev_b || rdy_b)) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_word: got data 0x%0h, expected no word", data_b);
        end else begin
          exp_b = q_b.pop_front();
          chk("b_data",       32'(data_b), 32'(exp_b[7:0]));
          chk("b_frame_err",  32'(fe_b),   32'(exp_b[8]));
          chk("b_parity_err", 32'(pe_b),   32'(exp_b[9]));
        end
      end
      vprev_b = val_b;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    drive_a(1'b1, 2 * CPB);

    // Basic 8N1 word
    q_a.push_back(pack(8'hA5, 1'b0, 1'b0));
    frame_a(8'hA5, 1'b1, -1);
    drive_a(1'b1, 2 * CPB);

    // Even parity: 0x07 has three ones, parity bit 0 is wrong, 1 is right
    q_b.push_back(pack(8'h07, 1'b0, 1'b1));
    frame_b(8'h07, 1'b0);
    drive_b(1'b1, 2 * CPB);
    q_b.push_back(pack(8'h07, 1'b0, 1'b0));
    frame_b(8'h07, 1'b1);
    drive_b(1'b1, 2 * CPB);

    // Framing error then a clean frame
    q_a.push_back(pack(8'h3C, 1'b1, 1'b0));
    frame_a(8'h3C, 1'b0, -1);
    drive_a(1'b1, 2 * CPB);
    q_a.push_back(pack(8'h11, 1'b0, 1'b0));
    frame_a(8'h11, 1'b1, -1);
    drive_a(1'b1, 2 * CPB);
    chk("a_queue_after_basic", 32'(q_a.size()), 32'h0);
    chk("b_queue_after_parity", 32'(q_b.size()), 32'h0);

    // Idle-line low glitch must not produce a word
    drive_a(1'b0, 1);
    drive_a(1'b1, 3 * CPB);

    // High glitch in the middle of data bit 3 of 0x00 is voted out
    q_a.push_back(pack(8'h00, 1'b0, 1'b0));
    frame_a(8'h00, 1'b1, 3);
    drive_a(1'b1, 2 * CPB);
    chk("a_queue_after_glitch", 32'(q_a.size()), 32'h0);

    // Line low for 12 bit times
`ifdef UART_RX_BREAK_EN
    exp_brk = 1;
`else
    exp_brk = 0;
    q_a.push_back(pack(8'h00, 1'b1, 1'b0));
`endif
    drive_a(1'b0, 12 * CPB);
    drive_a(1'b1, 2 * CPB);
    chk("a_break_pulses", 32'(n_brk_a), 32'(exp_brk));
    chk("a_queue_after_break", 32'(q_a.size()), 32'h0);

    // Overrun: consumer stalled, second word dropped
    rdy_a = 1'b0;
    q_a.push_back(pack(8'h01, 1'b0, 1'b0));
    frame_a(8'h01, 1'b1, -1);
    drive_a(1'b1, 2 * CPB);
    frame_a(8'h02, 1'b1, -1);
    drive_a(1'b1, 2 * CPB);
    chk("a_overrun_count", 32'(n_ovr_a), 32'h1);
    chk("a_held_valid", 32'(val_a), 32'h1);
    chk("a_held_data", 32'(data_a), 32'h01);

    // Third word: ready raised exactly at its completion cycle
    q_a.push_back(pack(8'h03, 1'b0, 1'b0));
    fork
      frame_a(8'h03, 1'b1, -1);
      begin
        repeat (156) @(negedge clk);
        rdy_a = 1'b1;
      end
    join
    drive_a(1'b1, 2 * CPB);
    chk("a_overrun_after_third", 32'(n_ovr_a), 32'h1);
    chk("a_queue_after_overrun", 32'(q_a.size()), 32'h0);
    chk("a_valid_drained", 32'(val_a), 32'h0);

    // Reset in the middle of data bit 4 of 0x55 aborts the frame
    drive_a(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_a(((8'h55 >> i) & 8'h01) != 0, CPB);
    drive_a(1'b1, 8);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    drive_a(1'b1, 2 * CPB);
    q_a.push_back(pack(8'h9A, 1'b0, 1'b0));
    frame_a(8'h9A, 1'b1, -1);
    drive_a(1'b1, 2 * CPB);

    chk("a_queue_final", 32'(q_a.size()), 32'h0);
    chk("b_queue_final", 32'(q_b.size()), 32'h0);
    chk("a_overrun_final", 32'(n_ovr_a), 32'h1);
    chk("b_overrun_final", 32'(n_ovr_b), 32'h0);
    chk("b_break_final", 32'(n_brk_b), 32'h0);
    chk("a_break_final", 32'(n_brk_a), 32'(exp_brk));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
